// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC/IR, request/acknowledge handshake to instruction
// memory, and decoded instruction fields for the control FSM.
module fetch_unit #(
    parameter int unsigned    AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter int unsigned    TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          fetch_start,
    input  logic          ld_branch,
    input  logic [AW-1:0] br_addr,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic [AW-1:0] pc_out,
    output logic [3:0]    opcode,
    output logic [3:0]    mm,
    output logic [3:0]    rd,
    output logic [3:0]    rs,
    output logic [3:0]    rt,
    output logic [15:0]   imm,
    output logic          fetch_done,
    output logic          fetch_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [31:0]   ir, ir_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic          req, req_nxt;
    logic          err, err_nxt;
    logic [AW-1:0] next_pc;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= IDLE;
            pc    <= RESET_PC;
            addr  <= '0;
            ir    <= '0;
            cnt   <= '0;
            req   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            addr  <= addr_nxt;
            ir    <= ir_nxt;
            cnt   <= cnt_nxt;
            req   <= req_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        addr_nxt  = addr;
        ir_nxt    = ir;
        cnt_nxt   = cnt;
        req_nxt   = req;
        err_nxt   = err;
        next_pc   = ld_branch ? br_addr : pc;
        case (state)
            IDLE: begin
                // A simultaneous branch and fetch both take effect; the fetch uses the target
                pc_nxt = next_pc;
                if (fetch_start) begin
                    addr_nxt  = next_pc;
                    req_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    pc_nxt    = addr + 1'b1;
                    req_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = ERR;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = ERR;
        endcase
    end

    assign imem_req   = req;
    assign imem_addr  = addr;
    assign pc_out     = pc;
    assign fetch_err  = err;
    assign fetch_done = (state == DONE);
    assign opcode     = ir[31:28];
    assign mm         = ir[27:24];
    assign rd         = ir[23:20];
    assign rs         = ir[19:16];
    assign rt         = ir[15:12];
    assign imm        = ir[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetches push expected PC/IR, a monitor
// checks them on each fetch_done pulse.
module tb_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] ir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        fetch_start;
    logic        ld_branch;
    logic [15:0] br_addr;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [15:0] pc_out;
    logic [3:0]  opcode, mm, rd, rs, rt;
    logic [15:0] imm;
    logic        fetch_done;
    logic        fetch_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    exp_t sb[$];

    logic [15:0] model_pc;
    logic [31:0] model_ir;

    fetch_unit #(.AW(16), .RESET_PC(16'h0000), .TIMEOUT(4)) dut (
        .clk(clk), .rst_f(rst_f), .fetch_start(fetch_start), .ld_branch(ld_branch),
        .br_addr(br_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
        .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .fetch_done(fetch_done), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every fetch_done pulse must match the oldest outstanding fetch
    always @(negedge clk) begin
        exp_t e;
        if (rst_f === 1'b1 && fetch_done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("mon_pc", {16'h0, pc_out}, {16'h0, e.pc});
                chk("mon_ir", {opcode, mm, rd, rs, imm}, e.ir);
                chk("mon_rt", {28'h0, rt}, {28'h0, e.ir[15:12]});
                chk("mon_req_low", {31'h0, imem_req}, 32'd0);
            end
        end
    end

    task automatic branch_only(input logic [15:0] target);
        ld_branch = 1'b1;
        br_addr   = target;
        @(negedge clk);
        ld_branch = 1'b0;
        model_pc  = target;
        chk("branch_pc", {16'h0, pc_out}, {16'h0, target});
        chk("branch_no_req", {31'h0, imem_req}, 32'd0);
    endtask

    // Issues one fetch; returns at a negedge in IDLE after the DONE cycle
    task automatic fetch(input logic br, input logic [15:0] target, input int waits,
                         input logic [31:0] data, input logic [15:0] exp_addr);
        fetch_start = 1'b1;
        ld_branch   = br;
        br_addr     = target;
        if (br) model_pc = target;
        @(negedge clk);
        fetch_start = 1'b0;
        ld_branch   = 1'b0;
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", {31'h0, imem_req}, 32'd1);
            chk("wait_addr", {16'h0, imem_addr}, {16'h0, exp_addr});
            chk("wait_ir_hold", {opcode, mm, rd, rs, imm}, model_ir);
            chk("wait_pc_hold", {16'h0, pc_out}, {16'h0, model_pc});
            @(negedge clk);
        end
        chk("ack_req", {31'h0, imem_req}, 32'd1);
        chk("ack_addr", {16'h0, imem_addr}, {16'h0, exp_addr});
        imem_ack   = 1'b1;
        imem_rdata = data;
        model_pc   = exp_addr + 16'd1;
        model_ir   = data;
        sb.push_back('{pc: model_pc, ir: data});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hA5A5_5A5A;
        @(negedge clk);
        chk("idle_done_low", {31'h0, fetch_done}, 32'd0);
    endtask

    initial begin
        int n;
        rst_f = 1'b0; fetch_start = 1'b0; ld_branch = 1'b0; br_addr = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        model_pc = 16'h0000; model_ir = '0;
        repeat (2) @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);

        // Reset values, then async reset in the middle of a request
        chk("rst_pc", {16'h0, pc_out}, 32'd0);
        chk("rst_opcode", {28'h0, opcode}, 32'd0);
        chk("rst_done", {31'h0, fetch_done}, 32'd0);
        chk("rst_err", {31'h0, fetch_err}, 32'd0);
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        fetch_start = 1'b1; ld_branch = 1'b1; br_addr = 16'h0040;
        @(negedge clk);
        fetch_start = 1'b0; ld_branch = 1'b0;
        chk("pre_rst_req", {31'h0, imem_req}, 32'd1);
        chk("pre_rst_addr", {16'h0, imem_addr}, 32'h0040);
        @(posedge clk);
        #2;
        rst_f = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("async_req_drop", {31'h0, imem_req}, 32'd0);
        @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("post_rst_ir", {opcode, mm, rd, rs, imm}, 32'd0);
        chk("post_rst_pc", {16'h0, pc_out}, 32'd0);
        chk("post_rst_addr", {16'h0, imem_addr}, 32'd0);
        chk("post_rst_done", {31'h0, fetch_done}, 32'd0);
        chk("post_rst_req", {31'h0, imem_req}, 32'd0);

        // Zero-wait fetch at 0x0010
        branch_only(16'h0010);
        fetch(1'b0, 16'h0000, 0, 32'h1A23_4567, 16'h0010);
        chk("zw_opcode", {28'h0, opcode}, 32'h1);
        chk("zw_mm", {28'h0, mm}, 32'hA);
        chk("zw_rd", {28'h0, rd}, 32'h2);
        chk("zw_rs", {28'h0, rs}, 32'h3);
        chk("zw_rt", {28'h0, rt}, 32'h4);
        chk("zw_imm", {16'h0, imm}, 32'h4567);
        chk("zw_pc", {16'h0, pc_out}, 32'h0011);

        // Three-wait fetch: ack lands on the last legal REQ cycle (TIMEOUT = 4)
        fetch(1'b0, 16'h0000, 3, 32'h5B6C_7D8E, 16'h0011);
        chk("w3_pc", {16'h0, pc_out}, 32'h0012);
        chk("w3_err", {31'h0, fetch_err}, 32'd0);

        // Branch and fetch in the same cycle
        fetch(1'b1, 16'h0200, 1, 32'h2000_0200, 16'h0200);
        chk("br_pc", {16'h0, pc_out}, 32'h0201);

        // PC wrap, then stray ack in IDLE
        branch_only(16'hFFFF);
        fetch(1'b0, 16'h0000, 0, 32'hC3C3_1234, 16'hFFFF);
        chk("wrap_pc", {16'h0, pc_out}, 32'h0000);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        chk("stray_opcode", {28'h0, opcode}, 32'hC);
        chk("stray_imm", {16'h0, imm}, 32'h1234);
        chk("stray_req", {31'h0, imem_req}, 32'd0);

        // Timeout with no ack
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        n = 0;
        while (imem_req === 1'b1 && n < 20) begin
            chk("to_err_low", {31'h0, fetch_err}, 32'd0);
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", n, 32'd4);
        chk("to_err_set", {31'h0, fetch_err}, 32'd1);
        fetch_start = 1'b1; ld_branch = 1'b1; br_addr = 16'h1234; imem_ack = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0; ld_branch = 1'b0;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        chk("err_req_ignored", {31'h0, imem_req}, 32'd0);
        chk("err_sticky", {31'h0, fetch_err}, 32'd1);
        chk("err_pc_hold", {16'h0, pc_out}, 32'h0000);
        chk("err_ir_hold", {opcode, mm, rd, rs, imm}, 32'hC3C3_1234);
        rst_f = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);
        chk("rerst_err", {31'h0, fetch_err}, 32'd0);
        chk("rerst_req", {31'h0, imem_req}, 32'd0);

        chk("done_pulses", n_done, 32'd4);
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the SISC datapath: holds the program counter (PC) and instruction register (IR), runs the request/acknowledge handshake to instruction memory, and presents the decoded fields (opcode, mm, register numbers, immediate) to the control FSM. It is the producer side of the controller's opcode/mm inputs. The controller starts a fetch with `fetch_start` in its fetch state and redirects the PC with `ld_branch` for branch, jump, call and return instructions.

## Interface
- `AW`, 16: PC / instruction-memory address width.
- `RESET_PC`, 0: PC value loaded on reset.
- `TIMEOUT`, 15: maximum wait cycles for `imem_ack`. Legal range 1..255.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst_f`  in  1: reset, asynchronous, active-low.
- `fetch_start`  in  1: request one instruction fetch; honoured only in IDLE.
- `ld_branch`  in  1: load the PC from `br_addr`; honoured only in IDLE.
- `br_addr`  in  AW: branch/jump target.
- `imem_req`  out  1: memory request, registered.
- `imem_addr`  out  AW: address of the current request, registered.
- `imem_ack`  in  1: memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  32: instruction word.
- `pc_out`  out  AW: current PC.
- `opcode`  out  4: IR[31:28].
- `mm`  out  4: IR[27:24].
- `rd`, `rs`, `rt`  out  4 each: IR[23:20], IR[19:16] and IR[15:12].
- `imm`  out  16: IR[15:0].
- `fetch_done`  out  1: one-cycle pulse when the IR has been updated.
- `fetch_err`  out  1: sticky timeout flag.

## Operation
- **States:** IDLE, REQ, DONE, ERR.
- **Reset (async, `rst_f` = 0):**
  - state = IDLE; PC = RESET_PC; IR = 0 (a NOOP); wait counter = 0.
  - `imem_req` = 0, `imem_addr` = 0, `fetch_done` = 0, `fetch_err` = 0.
  - All decoded field outputs are 0.
- **IDLE:**
  - next_pc = `ld_branch` ? `br_addr` : PC.
  - If `ld_branch` is high, PC ← `br_addr`.
  - If `fetch_start` is high: `imem_addr` ← next_pc, `imem_req` ← 1, counter ← 0, go to REQ.
  - If both are high in the same cycle, both are accepted and the fetch uses `br_addr`.
- **REQ:**
  - If `imem_ack` is high: IR ← `imem_rdata`, PC ← `imem_addr` + 1 (modulo 2^AW, so all-ones wraps to 0), `imem_req` ← 0, go to DONE.
  - Else if counter == TIMEOUT − 1: `imem_req` ← 0, `fetch_err` ← 1, go to ERR.
  - Otherwise counter ← counter + 1.
  - `fetch_start` and `ld_branch` are ignored in this state.
- **DONE:** `fetch_done` = 1 for exactly this cycle, then go to IDLE. Inputs are ignored.
- **ERR:** terminal state. The IR and PC hold their values and all inputs are ignored; only reset leaves ERR.
- **Unexpected ack:** `imem_ack` outside REQ is ignored, and the IR does not change.
- **Decoded fields:** combinational slices of the IR. They change only on the edge that captures `imem_rdata`.
- **Counter:** 8 bits wide; it never exceeds TIMEOUT − 1.

## Timing
- **Request launch:** `fetch_start` sampled at edge N → `imem_req` and `imem_addr` valid from N to N+1.
- **Capture:**
  - Ack with zero wait (high in the first REQ cycle): the IR and PC update at edge N+1 and `fetch_done` is high from N+1 to N+2.
  - Each cycle of ack delay adds one cycle of latency.
  - The minimum fetch-to-fetch period is 3 cycles (REQ, DONE, IDLE).
- **Timeout:** with no ack, `imem_req` is high for exactly TIMEOUT cycles. `fetch_err` rises on the same edge that drops `imem_req`.
- **Request stability:** `imem_addr` is stable for the whole time `imem_req` is high. `imem_req` never re-asserts without a new `fetch_start`.
- **Reset mid-request:** `imem_req` drops immediately on `rst_f` falling, without waiting for a clock edge. An ack arriving during or after reset is discarded.
- **Controller contract:** the controller holds `fetch_start` for one cycle only. The IR is valid for decode from the cycle after `fetch_done` until the next capture.

## Test plan
1. **Reset values:** assert `rst_f` = 0 mid-cycle → `imem_req` = 0 immediately; after release, `pc_out` = 0x0000, `opcode` = 0, `fetch_done` = 0 and `fetch_err` = 0.
2. **Zero-wait fetch:** `fetch_start` at PC 0x0010, ack in the first REQ cycle with `imem_rdata` = 0x1A23_4567 → `imem_addr` = 0x0010 for 1 cycle; `opcode` = 1, `mm` = 0xA, `rd` = 2, `rs` = 3, `rt` = 4, `imm` = 0x4567; `pc_out` = 0x0011; one `fetch_done` pulse.
3. **Three-wait fetch:** ack delayed 3 cycles → `imem_req` is high for 4 cycles, the IR updates only on the ack edge, and `fetch_done` is a single pulse.
4. **Branch with fetch:** `ld_branch` and `fetch_start` in the same cycle with `br_addr` = 0x0200 → `imem_addr` = 0x0200, and `pc_out` = 0x0201 after the ack.
5. **Wrap and stray ack:** PC = 0xFFFF, fetch acked → `pc_out` = 0x0000; then a stray `imem_ack` in IDLE leaves the IR unchanged.
6. **Timeout:** TIMEOUT = 4 with no ack → `imem_req` is high for exactly 4 cycles and `fetch_err` = 1 stays set. A later `fetch_start` is ignored until reset, after which `fetch_err` = 0.
